oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL provide parameter TRIGGER_ADDR, default 16'h4014, meaning the CPU write address that starts a transfer.
REQ-002 SHALL provide parameter OAM_DATA_ADDR, default 16'h2004, meaning the PPU OAM data port that receives every copied byte.
REQ-003 SHALL have port clk_ph1  input  1  meaning the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port cpu_addr  input  16  meaning the CPU address bus.
REQ-006 SHALL have port cpu_dout  input  8  meaning the CPU write data.
REQ-007 SHALL have port cpu_rw  input  1  meaning CPU direction: 1 = read, 0 = write.
REQ-008 SHALL have port Data_bus  input  8  meaning the system read-data bus.
REQ-009 SHALL have port cpu_rdy  output  1  meaning the CPU RDY line: 0 stalls the CPU.
REQ-010 SHALL have port bus_own  output  1  meaning 1 while the DMA block drives the system address and r/w lines.
REQ-011 SHALL have port dma_addr  output  16  meaning the DMA address.
REQ-012 SHALL have port dma_dout  output  8  meaning the DMA write data.
REQ-013 SHALL have port dma_rw  output  1  meaning DMA direction: 1 = read, 0 = write.
REQ-014 SHALL have port dma_active  output  1  meaning 1 in any state other than IDLE.

Function
REQ-015 SHALL keep a parity bit that toggles every clock, with 0 after reset.
REQ-016 SHALL implement the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-017 In IDLE, a cycle with cpu_rw=0 and cpu_addr=TRIGGER_ADDR SHALL latch page=cpu_dout, clear idx to 0 and go to HALT.
REQ-018 Any other access, including a read of TRIGGER_ADDR, SHALL NOT trigger a transfer.
REQ-019 In HALT, cpu_rdy SHALL be 0 and bus_own SHALL be 0.
REQ-020 HALT SHALL remain while cpu_rdy=0 and cpu_rw=0, because the CPU cannot stall on write cycles.
REQ-021 On a HALT cycle with cpu_rw=1, the block SHALL go to READ when parity=1 and to ALIGN when parity=0.
REQ-022 ALIGN SHALL last exactly 1 cycle, with cpu_rdy=0 and bus_own=0, and then go to READ.
REQ-023 READ SHALL occur only when parity=0.
REQ-024 In READ, dma_addr SHALL be {page,idx}, dma_rw SHALL be 1 and bus_own SHALL be 1.
REQ-025 At the end of each READ cycle, Data_bus SHALL be latched into a byte register, and the state SHALL go to WRITE.
REQ-026 In WRITE, dma_addr SHALL be OAM_DATA_ADDR, dma_rw SHALL be 0, dma_dout SHALL be the latched byte and bus_own SHALL be 1.
REQ-027 Each WRITE SHALL increment the 8-bit idx.
REQ-028 If idx was 8'hFF on a WRITE, the block SHALL go to IDLE; otherwise it SHALL go to READ.
REQ-029 idx SHALL wrap 8'hFF->8'h00 with no carry into page, so exactly 256 bytes are copied from {page,00}..{page,FF}.
REQ-030 With an immediate CPU read, the stall (cpu_rdy=0) SHALL last 513 cycles when HALT parity=1 and 514 cycles when HALT parity=0.
REQ-031 Every HALT cycle extended by a CPU write SHALL add one cycle to that stall.
REQ-032 cpu_rdy SHALL return to 1 in the first IDLE cycle after the final WRITE.
REQ-033 Bus signals SHALL be ignored for triggering outside IDLE; a write to TRIGGER_ADDR during a transfer has no effect.
REQ-034 Outside READ and WRITE, dma_addr, dma_dout and dma_rw SHALL hold their last values, and bus_own SHALL be 0.
REQ-035 All outputs SHALL be registered, with no combinational path from inputs to cpu_rdy or bus_own.

Reset
REQ-036 While rst=0, the block SHALL immediately force the state to IDLE, independent of clk_ph1.
REQ-037 While rst=0, the block SHALL hold cpu_rdy=1, bus_own=0, dma_active=0, dma_rw=1, dma_addr=16'h0000, dma_dout=8'h00, page=0, idx=0 and parity=0.
REQ-038 Reset mid-transfer SHALL abandon the transfer with no further OAM writes.
REQ-039 After reset releases, the next trigger SHALL restart from idx=0.

Verification
REQ-040 Reset scenario: hold rst=0, then release -> all outputs at their reset values, with cpu_rdy=1 on the first clock.
REQ-041 Odd-parity scenario: write 8'h02 to 16'h4014 so that HALT parity=1, with the CPU reading next and memory returning low address byte XOR 8'h5A -> cpu_rdy low for 513 cycles.
REQ-042 In that odd-parity scenario, reads SHALL alternate with writes: reads at 16'h0200..16'h02FF and writes at 16'h2004 carrying 8'h5A, 8'h5B, ..., 8'hA5.
REQ-043 Even-parity scenario: repeat the odd-parity scenario with HALT parity=0 -> exactly one ALIGN cycle and 514 stall cycles.
REQ-044 Write-extension scenario: keep cpu_rw=0 for 2 cycles after the trigger -> HALT lasts 3 cycles and the stall becomes 515 or 516 cycles.
REQ-045 Page-wrap scenario: trigger with page 8'hFF -> last read at 16'hFFFF, followed by IDLE, with no access to 16'h0000.
REQ-046 Mid-transfer reset scenario: assert rst after 100 writes, then retrigger with 8'h03 -> cpu_rdy=1 immediately, and the new transfer starts at 16'h0300.
REQ-047 Non-trigger scenario: read 16'h4014 and write 16'h4015 -> dma_active stays 0.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma: sprite OAM DMA engine. A CPU write of a page number to
// TRIGGER_ADDR stalls the CPU and copies {page,00}..{page,FF} to OAM_DATA_ADDR.
// Ports: clk_ph1/rst (async, active low); cpu_addr/cpu_dout/cpu_rw snoop the CPU;
// Data_bus is read data; cpu_rdy stalls the CPU; bus_own/dma_addr/dma_dout/dma_rw
// drive the system bus; dma_active flags any non-idle state. All outputs registered.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  Data_bus,
    output logic        cpu_rdy,
    output logic        bus_own,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_rw,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        parity;
    logic [7:0]  page;
    logic [7:0]  page_nx;
    logic [7:0]  idx;
    logic [7:0]  idx_nx;
    logic [7:0]  data_q;
    logic [7:0]  data_nx;
    logic [15:0] addr_nx;
    logic [7:0]  dout_nx;
    logic        rw_nx;

    always_comb begin
        state_nx = state;
        page_nx  = page;
        idx_nx   = idx;
        data_nx  = data_q;
        unique case (state)
            IDLE: begin
                if (!cpu_rw && cpu_addr == TRIGGER_ADDR) begin
                    page_nx  = cpu_dout;
                    idx_nx   = 8'h00;
                    state_nx = HALT;
                end
            end
            // The CPU only honours RDY on read cycles, so wait for one.
            // Reads must land on even parity; ALIGN burns the odd cycle.
            HALT: begin
                if (cpu_rw) begin
                    state_nx = parity ? READ : ALIGN;
                end
            end
            ALIGN: state_nx = READ;
            READ: begin
                data_nx  = Data_bus;
                state_nx = WRITE;
            end
            WRITE: begin
                idx_nx   = idx + 8'd1;
                state_nx = (idx == 8'hFF) ? IDLE : READ;
            end
            default: state_nx = IDLE;
        endcase

        // Bus outputs are computed for the coming state so they can be
        // registered; outside READ/WRITE they hold.
        addr_nx = dma_addr;
        dout_nx = dma_dout;
        rw_nx   = dma_rw;
        if (state_nx == READ) begin
            addr_nx = {page_nx, idx_nx};
            rw_nx   = 1'b1;
        end else if (state_nx == WRITE) begin
            addr_nx = OAM_DATA_ADDR;
            rw_nx   = 1'b0;
            dout_nx = data_nx;
        end
    end

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            parity     <= 1'b0;
            page       <= 8'h00;
            idx        <= 8'h00;
            data_q     <= 8'h00;
            cpu_rdy    <= 1'b1;
            bus_own    <= 1'b0;
            dma_active <= 1'b0;
            dma_rw     <= 1'b1;
            dma_addr   <= 16'h0000;
            dma_dout   <= 8'h00;
        end else begin
            state      <= state_nx;
            parity     <= ~parity;
            page       <= page_nx;
            idx        <= idx_nx;
            data_q     <= data_nx;
            cpu_rdy    <= (state_nx == IDLE);
            bus_own    <= (state_nx == READ) || (state_nx == WRITE);
            dma_active <= (state_nx != IDLE);
            dma_rw     <= rw_nx;
            dma_addr   <= addr_nx;
            dma_dout   <= dout_nx;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for oam_dma. Expected bus transfers are queued
// when a trigger is driven and popped as the DMA drives the bus.
module tb_oam_dma;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_rw = 1'b1;
    logic [7:0]  Data_bus = 8'h00;
    logic        cpu_rdy;
    logic        bus_own;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_rw;
    logic        dma_active;

    oam_dma dut (
        .clk_ph1   (clk_ph1),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_rw    (cpu_rw),
        .Data_bus  (Data_bus),
        .cpu_rdy   (cpu_rdy),
        .bus_own   (bus_own),
        .dma_addr  (dma_addr),
        .dma_dout  (dma_dout),
        .dma_rw    (dma_rw),
        .dma_active(dma_active)
    );

    always #5 clk_ph1 = ~clk_ph1;

    typedef struct packed {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
    } xfer_t;

    xfer_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          stall = 0;
    int          writes = 0;
    int unsigned pc = 0;

    // Edges since reset release; parity model is pc % 2.
    always @(posedge clk_ph1 or negedge rst) begin
        if (!rst) pc <= 0;
        else pc <= pc + 1;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        xfer_t e;
        @(negedge clk_ph1);
        if (!cpu_rdy) stall++;
        if (sb.size() == 0) begin
            chk("bus_own_idle", {31'd0, bus_own}, 32'd0);
        end else if (bus_own) begin
            e = sb.pop_front();
            chk("dma_addr", {16'd0, dma_addr}, {16'd0, e.a});
            chk("dma_rw", {31'd0, dma_rw}, {31'd0, e.rw});
            if (!e.rw) begin
                chk("dma_dout", {24'd0, dma_dout}, {24'd0, e.d});
                writes++;
            end
        end
        Data_bus = dma_addr[7:0] ^ 8'h5A;
    endtask

    task automatic run(logic [7:0] page, bit par, int extra, int abort_after);
        int exp_stall;
        bit fin;
        int n;
        xfer_t e;
        n = 0;
        while ((((pc + 1) % 2) != par) && n < 4) begin
            step();
            n++;
        end
        for (int i = 0; i < 256; i++) begin
            e.a  = {page, 8'(i)};
            e.rw = 1'b1;
            e.d  = 8'h00;
            sb.push_back(e);
            e.a  = 16'h2004;
            e.rw = 1'b0;
            e.d  = 8'(i) ^ 8'h5A;
            sb.push_back(e);
        end
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
        cpu_dout = page;
        stall    = 0;
        writes   = 0;
        step();
        chk("halt_rdy", {31'd0, cpu_rdy}, 32'd0);
        chk("halt_bus_own", {31'd0, bus_own}, 32'd0);
        chk("halt_active", {31'd0, dma_active}, 32'd1);
        // CPU keeps writing the trigger address; must not retrigger.
        cpu_dout = ~page;
        for (int k = 0; k < extra; k++) begin
            step();
            chk("ext_rdy", {31'd0, cpu_rdy}, 32'd0);
            chk("ext_bus_own", {31'd0, bus_own}, 32'd0);
        end
        cpu_addr = 16'h0000;
        cpu_rw   = 1'b1;
        fin = par ^ extra[0];
        exp_stall = 513 + extra + (fin ? 0 : 1);
        n = 0;
        while (cpu_rdy == 1'b0 && n < 700 &&
               !(abort_after > 0 && writes >= abort_after)) begin
            step();
            n++;
        end
        if (abort_after > 0) begin
            chk("abort_writes", writes, abort_after);
        end else begin
            chk("stall", stall, exp_stall);
            chk("sb_empty", sb.size(), 0);
            chk("done_active", {31'd0, dma_active}, 32'd0);
            for (int k = 0; k < 3; k++) step();
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rst_bus_own", {31'd0, bus_own}, 32'd0);
        chk("rst_active", {31'd0, dma_active}, 32'd0);
        chk("rst_rw", {31'd0, dma_rw}, 32'd1);
        chk("rst_addr", {16'd0, dma_addr}, 32'd0);
        chk("rst_dout", {24'd0, dma_dout}, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("post_rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("post_rst_active", {31'd0, dma_active}, 32'd0);

        cpu_addr = 16'h4014;
        cpu_rw   = 1'b1;
        step();
        chk("read_trig_active", {31'd0, dma_active}, 32'd0);
        cpu_addr = 16'h4015;
        cpu_rw   = 1'b0;
        cpu_dout = 8'h07;
        step();
        chk("w4015_active", {31'd0, dma_active}, 32'd0);
        cpu_addr = 16'h0000;
        cpu_rw   = 1'b1;
        step();
        chk("nontrig_active", {31'd0, dma_active}, 32'd0);
        chk("nontrig_rdy", {31'd0, cpu_rdy}, 32'd1);

        run(8'h02, 1'b1, 0, 0);
        run(8'h02, 1'b0, 0, 0);
        run(8'h10, 1'b1, 2, 0);
        run(8'h11, 1'b0, 2, 0);
        run(8'hFF, 1'b1, 0, 0);

        run(8'h40, 1'b1, 0, 100);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("mid_rst_bus_own", {31'd0, bus_own}, 32'd0);
        chk("mid_rst_active", {31'd0, dma_active}, 32'd0);
        chk("mid_rst_rw", {31'd0, dma_rw}, 32'd1);
        chk("mid_rst_addr", {16'd0, dma_addr}, 32'd0);
        sb.delete();
        step();
        rst = 1'b1;
        step();
        run(8'h03, 1'b1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
